apb_master_arbiter: RTL

Shares one APB3 master port between NREQ local requesters, for example BFM command channels or CPU-side bridges. Each requester issues a single read or write. The block arbitrates round-robin, sequences the APB SETUP and ACCESS phases, and decodes a one-hot PSEL across 16 slave slots from address bits [27:24]. It waits on PREADY under a timeout guard and returns read data and error status to the winner.

---
 rtl/apb_master_arbiter_pkg.sv | 20 ++
 rtl/apb_master_arbiter_if.sv | 35 +++
 rtl/apb_master_arbiter_rr.sv | 31 +++
 rtl/apb_master_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the APB master arbiter: FSM encoding, PSEL decode
// field and bus width.
package apb_master_arbiter_pkg;

   localparam int APB_DW  = 32;
   localparam int SEL_MSB = 27;
   localparam int SEL_LSB = 24;
   localparam int NSLOTS  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   function automatic logic [NSLOTS-1:0] psel_decode(input logic [SEL_MSB-SEL_LSB:0] slot);
      return NSLOTS'(1) << slot;
   endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter; the master modport is
// the arbiter's view, the slave modport is the environment's view.
interface apb_master_arbiter_if
   import apb_master_arbiter_pkg::*;
#(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]        REQ;
   logic [NREQ*APB_DW-1:0] REQ_ADDR;
   logic [NREQ-1:0]        REQ_WRITE;
   logic [NREQ*APB_DW-1:0] REQ_WDATA;
   logic [NREQ-1:0]        ACK;
   logic [APB_DW-1:0]      RDATA;
   logic                   ERR;
   logic                   BUSY;
   logic [NSLOTS-1:0]      PSEL;
   logic [APB_DW-1:0]      PADDR;
   logic                   PWRITE;
   logic                   PENABLE;
   logic [APB_DW-1:0]      PWDATA;
   logic [APB_DW-1:0]      PRDATA;
   logic                   PREADY;
   logic                   PSLVERR;

   modport master (
      input  REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA, PRDATA, PREADY, PSLVERR,
      output ACK, RDATA, ERR, BUSY, PSEL, PADDR, PWRITE, PENABLE, PWDATA
   );

   modport slave (
      output REQ, REQ_ADDR, REQ_WRITE, REQ_WDATA, PRDATA, PREADY, PSLVERR,
      input  ACK, RDATA, ERR, BUSY, PSEL, PADDR, PWRITE, PENABLE, PWDATA
   );

endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin pick: searches from ptr+1 (mod NREQ) for the
// first active request; the pointer register lives in the parent.
module apb_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   int cand;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3 master port between NREQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, PSEL decode and a PREADY timeout guard.
module apb_master_arbiter
   import apb_master_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255,
   parameter int TOW     = 8
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_master_arbiter_if.master bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   apb_state_e state, state_nxt;
   logic [IW-1:0]     ptr, ptr_nxt, win, win_nxt, gnt_idx;
   logic [TOW-1:0]    tmo_cnt, tmo_nxt;
   logic [NREQ-1:0]   grant, ack_nxt;
   logic [APB_DW-1:0] rdata_nxt, paddr_nxt, pwdata_nxt, sel_addr, sel_wdata;
   logic [NSLOTS-1:0] psel_nxt;
   logic              err_nxt, busy_nxt, pwrite_nxt, penable_nxt, sel_write, done;

   apb_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
      .req   (bus.REQ),
      .ptr   (ptr),
      .grant (grant),
      .idx   (gnt_idx)
   );

   always_comb begin
      sel_addr  = '0;
      sel_write = 1'b0;
      sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr  = bus.REQ_ADDR[i*APB_DW +: APB_DW];
            sel_write = bus.REQ_WRITE[i];
            sel_wdata = bus.REQ_WDATA[i*APB_DW +: APB_DW];
         end
      end
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      win_nxt     = win;
      tmo_nxt     = tmo_cnt;
      ack_nxt     = '0;
      rdata_nxt   = bus.RDATA;
      err_nxt     = bus.ERR;
      psel_nxt    = bus.PSEL;
      paddr_nxt   = bus.PADDR;
      pwrite_nxt  = bus.PWRITE;
      penable_nxt = bus.PENABLE;
      pwdata_nxt  = bus.PWDATA;
      done        = 1'b0;
      case (state)
         IDLE: begin
            // Holding off while ACK is high leaves the winner a cycle to drop REQ.
            if (bus.ACK == '0 && grant != '0) begin
               paddr_nxt  = sel_addr;
               pwrite_nxt = sel_write;
               pwdata_nxt = sel_wdata;
               psel_nxt   = psel_decode(sel_addr[SEL_MSB:SEL_LSB]);
               ptr_nxt    = gnt_idx;
               win_nxt    = gnt_idx;
               state_nxt  = SETUP;
            end
         end
         SETUP: begin
            penable_nxt = 1'b1;
            tmo_nxt     = '0;
            state_nxt   = ACCESS;
         end
         ACCESS: begin
            if (bus.PREADY) begin
               rdata_nxt = bus.PWRITE ? '0 : bus.PRDATA;
               err_nxt   = bus.PSLVERR;
               done      = 1'b1;
            end else if (TIMEOUT != 0 && tmo_cnt == TOW'(TIMEOUT - 1)) begin
               rdata_nxt = '0;
               err_nxt   = 1'b1;
               done      = 1'b1;
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
            if (done) begin
               ack_nxt[win] = 1'b1;
               psel_nxt     = '0;
               penable_nxt  = 1'b0;
               paddr_nxt    = '0;
               pwrite_nxt   = 1'b0;
               pwdata_nxt   = '0;
               state_nxt    = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state       <= IDLE;
         ptr         <= IW'(NREQ - 1);
         win         <= '0;
         tmo_cnt     <= '0;
         bus.ACK     <= '0;
         bus.RDATA   <= '0;
         bus.ERR     <= 1'b0;
         bus.BUSY    <= 1'b0;
         bus.PSEL    <= '0;
         bus.PADDR   <= '0;
         bus.PWRITE  <= 1'b0;
         bus.PENABLE <= 1'b0;
         bus.PWDATA  <= '0;
      end else begin
         state       <= state_nxt;
         ptr         <= ptr_nxt;
         win         <= win_nxt;
         tmo_cnt     <= tmo_nxt;
         bus.ACK     <= ack_nxt;
         bus.RDATA   <= rdata_nxt;
         bus.ERR     <= err_nxt;
         bus.BUSY    <= busy_nxt;
         bus.PSEL    <= psel_nxt;
         bus.PADDR   <= paddr_nxt;
         bus.PWRITE  <= pwrite_nxt;
         bus.PENABLE <= penable_nxt;
         bus.PWDATA  <= pwdata_nxt;
      end
   end

endmodule
